// File: rtl/pico_sprite_ctrl_pkg.sv
// Shared definitions for the PicoBlaze sprite-layer controller:
// register offsets, status bit positions and the interrupt FSM states.
package pico_sprite_ctrl_pkg;

  localparam logic [2:0] OFS_FICHA_L = 3'd0;
  localparam logic [2:0] OFS_FICHA_H = 3'd1;
  localparam logic [2:0] OFS_NIVEL_L = 3'd2;
  localparam logic [2:0] OFS_NIVEL_H = 3'd3;
  localparam logic [2:0] OFS_FONDO   = 3'd4;
  localparam logic [2:0] OFS_CTRL    = 3'd5;
  localparam logic [2:0] OFS_FRAME   = 3'd6;
  localparam logic [2:0] OFS_STATUS  = 3'd7;

  localparam int ST_DIRTY  = 0;
  localparam int ST_VBLANK = 1;
  localparam int ST_IRQ    = 2;

  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_PEND = 1'b1
  } irq_state_e;

endpackage

// File: rtl/pico_sprite_ctrl_if.sv
// kcpsm3 I/O port bundle; the CPU side is the master, the peripheral the slave.
interface pico_sprite_ctrl_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/pico_sprite_ctrl_frame_tick_gen.sv
// Detects the first vblank line: registered one-cycle tick after pixel_y
// arrives at V_ACTIVE from any other value, plus a live in_vblank flag.
module frame_tick_gen #(
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_y,
  output logic       tick,
  output logic       in_vblank
);

  localparam logic [9:0] VA = V_ACTIVE[9:0];

  logic [9:0] prev_y_q, prev_y_d;
  logic       tick_q, tick_d;

  always_comb begin
    prev_y_d = pixel_y;
    tick_d   = (pixel_y == VA) && (prev_y_q != VA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_y_q <= 10'd0;
      tick_q   <= 1'b0;
    end else begin
      prev_y_q <= prev_y_d;
      tick_q   <= tick_d;
    end
  end

  assign tick      = tick_q;
  assign in_vblank = (pixel_y >= VA);

endmodule

// File: rtl/pico_sprite_ctrl.sv
// Sprite-layer I/O slave: CPU writes land in shadow registers which are
// copied to the active outputs atomically at vblank start or on force_commit.
module pico_sprite_ctrl
  import pico_sprite_ctrl_pkg::*;
#(
  parameter logic [7:0] BASE_ID     = 8'h10,
  parameter int         V_ACTIVE    = V_ACTIVE_DEF,
  parameter logic [9:0] FICHA_Y_RST = 10'd200,
  parameter logic [9:0] NIVEL_X_RST = 10'd400,
  parameter logic [3:0] FONDO_RST   = 4'b0011
) (
  input  logic                     CLK_50M,
  input  logic                     reset,
  pico_sprite_ctrl_if.slave        bus,
  input  logic [9:0]               pixel_y,
  output logic [9:0]               ficha_y,
  output logic [9:0]               nivel_x,
  output logic [3:0]               fondo
);

  logic tick, in_vblank;

  frame_tick_gen #(.V_ACTIVE(V_ACTIVE)) u_tick (
    .clk       (CLK_50M),
    .reset     (reset),
    .pixel_y   (pixel_y),
    .tick      (tick),
    .in_vblank (in_vblank)
  );

  logic [9:0] sh_ficha_q, sh_ficha_d, sh_nivel_q, sh_nivel_d;
  logic [3:0] sh_fondo_q, sh_fondo_d;
  logic [9:0] ficha_q, ficha_d, nivel_q, nivel_d;
  logic [3:0] fondo_q, fondo_d;
  logic       dirty_q, dirty_d, irq_en_q, irq_en_d;
  logic       force_commit_q, force_commit_d;
  logic [7:0] frame_cnt_q, frame_cnt_d, in_port_q, in_port_d;
  irq_state_e state_q, state_d;

  logic       hit, wr, commit;
  logic [2:0] ofs;

  assign hit    = (bus.port_id[7:3] == BASE_ID[7:3]);
  assign ofs    = bus.port_id[2:0];
  assign wr     = bus.write_strobe && hit;
  assign commit = (tick && dirty_q) || force_commit_q;

  // Commit reads the pre-write shadow, so a write in the commit cycle survives as dirty.
  always_comb begin
    sh_ficha_d     = sh_ficha_q;
    sh_nivel_d     = sh_nivel_q;
    sh_fondo_d     = sh_fondo_q;
    ficha_d        = ficha_q;
    nivel_d        = nivel_q;
    fondo_d        = fondo_q;
    dirty_d        = dirty_q;
    irq_en_d       = irq_en_q;
    force_commit_d = 1'b0;
    frame_cnt_d    = frame_cnt_q + {7'd0, tick};
    if (commit) begin
      ficha_d = sh_ficha_q;
      nivel_d = sh_nivel_q;
      fondo_d = sh_fondo_q;
      dirty_d = 1'b0;
    end
    if (wr) begin
      case (ofs)
        OFS_FICHA_L: begin sh_ficha_d[7:0] = bus.out_port;      dirty_d = 1'b1; end
        OFS_FICHA_H: begin sh_ficha_d[9:8] = bus.out_port[1:0]; dirty_d = 1'b1; end
        OFS_NIVEL_L: begin sh_nivel_d[7:0] = bus.out_port;      dirty_d = 1'b1; end
        OFS_NIVEL_H: begin sh_nivel_d[9:8] = bus.out_port[1:0]; dirty_d = 1'b1; end
        OFS_FONDO:   begin sh_fondo_d      = bus.out_port[3:0]; dirty_d = 1'b1; end
        OFS_CTRL: begin
          irq_en_d       = bus.out_port[0];
          force_commit_d = bus.out_port[1];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE: if (tick && irq_en_q) state_d = IRQ_PEND;
      IRQ_PEND: if (bus.interrupt_ack && !(tick && irq_en_q)) state_d = IRQ_IDLE;
      default:  state_d = IRQ_IDLE;
    endcase
  end

  always_comb begin
    in_port_d = 8'h00;
    if (hit) begin
      case (ofs)
        OFS_FRAME: in_port_d = frame_cnt_q;
        OFS_STATUS: begin
          in_port_d[ST_DIRTY]  = dirty_q;
          in_port_d[ST_VBLANK] = in_vblank;
          in_port_d[ST_IRQ]    = (state_q == IRQ_PEND);
        end
        default: in_port_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      sh_ficha_q     <= FICHA_Y_RST;
      sh_nivel_q     <= NIVEL_X_RST;
      sh_fondo_q     <= FONDO_RST;
      ficha_q        <= FICHA_Y_RST;
      nivel_q        <= NIVEL_X_RST;
      fondo_q        <= FONDO_RST;
      dirty_q        <= 1'b0;
      irq_en_q       <= 1'b0;
      force_commit_q <= 1'b0;
      frame_cnt_q    <= 8'h00;
      in_port_q      <= 8'h00;
      state_q        <= IRQ_IDLE;
    end else begin
      sh_ficha_q     <= sh_ficha_d;
      sh_nivel_q     <= sh_nivel_d;
      sh_fondo_q     <= sh_fondo_d;
      ficha_q        <= ficha_d;
      nivel_q        <= nivel_d;
      fondo_q        <= fondo_d;
      dirty_q        <= dirty_d;
      irq_en_q       <= irq_en_d;
      force_commit_q <= force_commit_d;
      frame_cnt_q    <= frame_cnt_d;
      in_port_q      <= in_port_d;
      state_q        <= state_d;
    end
  end

  assign ficha_y       = ficha_q;
  assign nivel_x       = nivel_q;
  assign fondo         = fondo_q;
  assign bus.in_port   = in_port_q;
  assign bus.interrupt = (state_q == IRQ_PEND);

endmodule
